pc_fetch: RTL and testbench
===========================

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001: The block SHALL use one clock and an asynchronous, active-high reset, with ports clk and rst.
REQ-002: Parameter DATA_WIDTH, default 32, SHALL set the instruction-address and immediate width.
REQ-003: Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC value loaded on reset.
REQ-004: Port clk  input  1  rising-edge clock for all state.
REQ-005: Port rst  input  1  asynchronous active-high reset.
REQ-006: Port en  input  1  advance enable; low SHALL hold PC (stall).
REQ-007: Port halt_req  input  1  request to stop fetching.
REQ-008: Port PCsrc  input  1  branch-taken select from the control unit.
REQ-009: Port ImmOp  input  DATA_WIDTH  sign-extended branch offset, byte units.
REQ-010: Port A  output  DATA_WIDTH  current PC, used as the instruction-memory address.
REQ-011: Port PCplus4  output  DATA_WIDTH  combinational A+4.
REQ-012: Port fetch_valid  output  1  high when A addresses an instruction to be executed.
REQ-013: Port halted  output  1  high in the HALT state.
REQ-014: Port misalign_err  output  1  sticky flag for a non-word-aligned branch target.
REQ-015: Port instr_count  output  32  count of instructions retired.

Function
REQ-016: The FSM SHALL have three states: BOOT, RUN and HALT.
REQ-017: Transition BOOT->RUN SHALL occur on the first clock edge after reset deasserts, with A unchanged on that edge.
REQ-018: In BOOT, fetch_valid SHALL be 0.
REQ-019: In RUN, fetch_valid SHALL equal en.
REQ-020: In RUN with en=1, the next PC SHALL be A+ImmOp when PCsrc=1, else A+4; the update SHALL be registered and visible on A one cycle later.
REQ-021: Each RUN cycle with en=1 that updates PC SHALL increment instr_count by 1.
REQ-022: PC and instr_count arithmetic SHALL be modulo 2^DATA_WIDTH and 2^32 respectively; A=32'hFFFF_FFFC with PCsrc=0 SHALL wrap to 32'h0000_0000.
REQ-023: In RUN with en=0, A, instr_count and state SHALL hold, and PCsrc SHALL be ignored.
REQ-024: In RUN with en=1, PCsrc=1 and (A+ImmOp)[1:0]!=0: A SHALL hold, misalign_err SHALL set, the state SHALL go to HALT, and instr_count SHALL not increment.
REQ-025: halt_req=1 in BOOT or RUN SHALL move the state to HALT on the next edge regardless of en.
REQ-026: halt_req SHALL take priority over a simultaneous PCsrc or misalignment; in that case A holds and misalign_err is not set.
REQ-027: HALT SHALL be exited only by rst.
REQ-028: In HALT: A and instr_count SHALL hold, fetch_valid SHALL be 0, and halted SHALL be 1.
REQ-029: misalign_err SHALL remain set until rst.
REQ-030: PCplus4 SHALL be A+4 in every state.

Reset
REQ-031: Asserting rst SHALL immediately, without a clock, set A=RESET_PC, state=BOOT, fetch_valid=0, halted=0, misalign_err=0 and instr_count=0.
REQ-032: Reset asserted mid-operation, including in HALT, SHALL abandon any pending branch and restart from BOOT.
REQ-033: Reset deassertion SHALL be treated as synchronous to clk by the integrating top.

Structure
REQ-034: The FSM state enum fetch_state_t, the constant INSTR_BYTES=4 and the default RESET_PC SHALL live in the shared package riscv_pkg.
REQ-035: Next-PC selection (A+4 / A+ImmOp plus the alignment check) SHALL be a combinational sub-module pc_next.
REQ-036: pc_fetch SHALL hold all registers (PC, FSM, counter, error flag).
REQ-037: A SHALL connect directly to the instruction-memory address input.

Verification
REQ-038: Reset release, en=1, PCsrc=0 for 4 edges -> A = 0,0,4,8,12; fetch_valid = 0,1,1,1; instr_count=3.
REQ-039: At A=0x10, PCsrc=1, ImmOp=0xFFFF_FFF8 -> next A=0x08; at A=0x08, ImmOp=0x6 -> A holds at 0x08, misalign_err=1, halted=1 on the following cycle.
REQ-040: en=0 for 3 cycles at A=0x20 while PCsrc toggles -> A stays 0x20, instr_count unchanged, fetch_valid=0.
REQ-041: halt_req=1 and PCsrc=1 (ImmOp=0x40) in the same cycle at A=0x30 -> A stays 0x30, halted=1, misalign_err=0; further edges leave A unchanged.
REQ-042: Force A=0xFFFF_FFFC with PCsrc=0 and en=1 -> A=0x0000_0000 and instr_count increments.
REQ-043: Assert rst between clock edges while in HALT -> outputs reach reset values before the next edge, then resume from BOOT.

Source files
------------

// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the instruction-fetch front end.
//   fetch_state_t    : fetch FSM states (BOOT, RUN, HALT)
//   INSTR_BYTES      : size of one instruction in bytes (sequential PC step)
//   DEFAULT_RESET_PC : PC value loaded on reset unless overridden
// ----------------------------------------------------------------------------
package riscv_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

   localparam int          INSTR_BYTES      = 4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage : riscv_pkg

// File: rtl/pc_next.sv
// ----------------------------------------------------------------------------
// pc_next
// Combinational next-PC selection for the fetch unit.
// Ports:
//   pc        in  DATA_WIDTH  current PC
//   imm       in  DATA_WIDTH  sign-extended branch offset (bytes)
//   pc_src    in  1           branch taken
//   next_pc   out DATA_WIDTH  pc+imm when pc_src, else pc+4
//   pc_plus4  out DATA_WIDTH  pc+4, always
//   misalign  out 1           taken branch whose target is not word aligned
// ----------------------------------------------------------------------------
module pc_next
   import riscv_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] pc,
   input  logic [DATA_WIDTH-1:0] imm,
   input  logic                  pc_src,
   output logic [DATA_WIDTH-1:0] next_pc,
   output logic [DATA_WIDTH-1:0] pc_plus4,
   output logic                  misalign
);

   logic [DATA_WIDTH-1:0] branch_target;

   // Both adds wrap naturally at 2^DATA_WIDTH.
   assign pc_plus4      = pc + DATA_WIDTH'(INSTR_BYTES);
   assign branch_target = pc + imm;
   assign next_pc       = pc_src ? branch_target : pc_plus4;

   // Only a taken branch can produce a misaligned target; pc+4 from an
   // aligned PC is always aligned.
   assign misalign = pc_src && (branch_target[1:0] != 2'b00);

endmodule : pc_next

// File: rtl/pc_fetch.sv
// ----------------------------------------------------------------------------
// pc_fetch
// Program counter and fetch-control FSM (BOOT -> RUN -> HALT).
// Ports:
//   clk           in  1           rising-edge clock
//   rst           in  1           asynchronous active-high reset
//   en            in  1           advance enable (low = stall)
//   halt_req      in  1           request to stop fetching
//   PCsrc         in  1           branch-taken select
//   ImmOp         in  DATA_WIDTH  sign-extended branch offset (bytes)
//   A             out DATA_WIDTH  current PC / instruction-memory address
//   PCplus4       out DATA_WIDTH  A+4 (combinational)
//   fetch_valid   out 1           A addresses an instruction to execute
//   halted        out 1           FSM is in HALT
//   misalign_err  out 1           sticky misaligned-branch flag
//   instr_count   out 32          instructions retired
// ----------------------------------------------------------------------------
module pc_fetch
   import riscv_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  halt_req,
   input  logic                  PCsrc,
   input  logic [DATA_WIDTH-1:0] ImmOp,
   output logic [DATA_WIDTH-1:0] A,
   output logic [DATA_WIDTH-1:0] PCplus4,
   output logic                  fetch_valid,
   output logic                  halted,
   output logic                  misalign_err,
   output logic [31:0]           instr_count
);

   fetch_state_t          state_reg, state_next;
   logic [DATA_WIDTH-1:0] pc_reg, pc_next_val;
   logic [31:0]           count_reg, count_next;
   logic                  err_reg, err_next;

   logic [DATA_WIDTH-1:0] target_pc;
   logic                  target_misalign;

   pc_next #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_pc_next (
      .pc       (pc_reg),
      .imm      (ImmOp),
      .pc_src   (PCsrc),
      .next_pc  (target_pc),
      .pc_plus4 (PCplus4),
      .misalign (target_misalign)
   );

   // State register: all architectural state lives here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= BOOT;
         pc_reg    <= RESET_PC;
         count_reg <= 32'd0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next_val;
         count_reg <= count_next;
         err_reg   <= err_next;
      end
   end

   // Next-state and outputs. Default is "hold everything".
   always_comb begin
      state_next  = state_reg;
      pc_next_val = pc_reg;
      count_next  = count_reg;
      err_next    = err_reg;
      fetch_valid = 1'b0;
      halted      = 1'b0;

      unique case (state_reg)
         BOOT: begin
            // First edge after reset only arms the FSM; PC is not advanced.
            state_next = halt_req ? HALT : RUN;
         end
         RUN: begin
            fetch_valid = en;
            if (halt_req) begin
               // halt_req wins over any branch or misalignment this cycle.
               state_next = HALT;
            end else if (en) begin
               if (target_misalign) begin
                  err_next   = 1'b1;
                  state_next = HALT;
               end else begin
                  pc_next_val = target_pc;
                  count_next  = count_reg + 32'd1;
               end
            end
         end
         HALT: begin
            halted = 1'b1;
         end
         default: begin
            state_next = BOOT;
         end
      endcase
   end

   assign A            = pc_reg;
   assign instr_count  = count_reg;
   assign misalign_err = err_reg;

endmodule : pc_fetch

// File: tb/tb_pc_fetch.sv
// ----------------------------------------------------------------------------
// tb_pc_fetch
// Directed self-checking bench for pc_fetch with hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_pc_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic        halt_req = 1'b0;
   logic        PCsrc = 1'b0;
   logic [31:0] ImmOp = 32'd0;
   logic [31:0] A;
   logic [31:0] PCplus4;
   logic        fetch_valid;
   logic        halted;
   logic        misalign_err;
   logic [31:0] instr_count;

   int errors = 0;
   int checks = 0;
   int cycle  = 0;

   pc_fetch #(
      .DATA_WIDTH (32),
      .RESET_PC   (32'h0000_0000)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .halt_req     (halt_req),
      .PCsrc        (PCsrc),
      .ImmOp        (ImmOp),
      .A            (A),
      .PCplus4      (PCplus4),
      .fetch_valid  (fetch_valid),
      .halted       (halted),
      .misalign_err (misalign_err),
      .instr_count  (instr_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one clock edge; sample 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
      cycle++;
      $display("cyc %0d: en=%0b hreq=%0b src=%0b imm=%08h -> A=%08h fv=%0b halted=%0b err=%0b cnt=%0d",
               cycle, en, halt_req, PCsrc, ImmOp, A, fetch_valid, halted, misalign_err, instr_count);
   endtask

   // Check the full reset-value set.
   task automatic check_reset_values(input string tag);
      check({tag, ".A"},      A,                    32'h0);
      check({tag, ".fv"},     {31'd0, fetch_valid}, 32'd0);
      check({tag, ".halted"}, {31'd0, halted},      32'd0);
      check({tag, ".err"},    {31'd0, misalign_err},32'd0);
      check({tag, ".cnt"},    instr_count,          32'd0);
   endtask

   // Synchronous release of reset after a clock edge.
   task automatic release_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      // ---------------- power-on reset ----------------
      en = 1'b1; PCsrc = 1'b0; ImmOp = 32'd0; halt_req = 1'b0;
      #2 rst = 1'b1;
      #1 check_reset_values("por");
      release_reset();
      check("boot.fv", {31'd0, fetch_valid}, 32'd0);
      check("boot.A",  A, 32'h0);

      // ---------------- sequential fetch: A = 0,4,8,12 ----------------
      step(); check("seq1.A", A, 32'h0);  check("seq1.fv", {31'd0, fetch_valid}, 32'd1);
      check("seq1.cnt", instr_count, 32'd0);
      step(); check("seq2.A", A, 32'h4);
      step(); check("seq3.A", A, 32'h8);
      step(); check("seq4.A", A, 32'hC);  check("seq4.cnt", instr_count, 32'd3);
      check("seq4.plus4", PCplus4, 32'h10);
      step(); check("seq5.A", A, 32'h10); check("seq5.cnt", instr_count, 32'd4);

      // ---------------- backward branch then misaligned branch ----------------
      PCsrc = 1'b1; ImmOp = 32'hFFFF_FFF8;
      step(); check("br_back.A", A, 32'h8); check("br_back.cnt", instr_count, 32'd5);
      ImmOp = 32'h6;
      step(); check("mis.A", A, 32'h8);
      check("mis.err", {31'd0, misalign_err}, 32'd1);
      check("mis.halted", {31'd0, halted}, 32'd1);
      check("mis.cnt", instr_count, 32'd5);
      check("mis.fv", {31'd0, fetch_valid}, 32'd0);
      PCsrc = 1'b0;
      step(); check("mis_hold.A", A, 32'h8); check("mis_hold.halted", {31'd0, halted}, 32'd1);

      // ---------------- reset between edges while in HALT ----------------
      #2 rst = 1'b1;
      #1 check_reset_values("halt_rst");
      release_reset();
      check("halt_rst_boot.halted", {31'd0, halted}, 32'd0);
      step(); check("halt_rst_run.fv", {31'd0, fetch_valid}, 32'd1);
      check("halt_rst_run.A", A, 32'h0);

      // ---------------- stall with toggling PCsrc at A=0x20 ----------------
      PCsrc = 1'b1; ImmOp = 32'h20;
      step(); check("to20.A", A, 32'h20); check("to20.cnt", instr_count, 32'd1);
      en = 1'b0; ImmOp = 32'h41;   // misaligned target must also be ignored
      for (int i = 0; i < 3; i++) begin
         PCsrc = (i % 2 == 0);
         #1 check("stall.fv", {31'd0, fetch_valid}, 32'd0);
         step();
         check("stall.A", A, 32'h20);
         check("stall.cnt", instr_count, 32'd1);
         check("stall.err", {31'd0, misalign_err}, 32'd0);
      end
      en = 1'b1; PCsrc = 1'b0;
      step(); check("after_stall.A", A, 32'h24); check("after_stall.cnt", instr_count, 32'd2);
      PCsrc = 1'b1; ImmOp = 32'hC;
      step(); check("to30.A", A, 32'h30); check("to30.cnt", instr_count, 32'd3);

      // ---------------- halt_req with simultaneous branch ----------------
      halt_req = 1'b1; PCsrc = 1'b1; ImmOp = 32'h40;
      step(); check("hreq.A", A, 32'h30);
      check("hreq.halted", {31'd0, halted}, 32'd1);
      check("hreq.err", {31'd0, misalign_err}, 32'd0);
      check("hreq.cnt", instr_count, 32'd3);
      halt_req = 1'b0;
      step(); step();
      check("hreq_hold.A", A, 32'h30); check("hreq_hold.halted", {31'd0, halted}, 32'd1);
      check("hreq_hold.plus4", PCplus4, 32'h34);

      // ---------------- halt_req in BOOT ----------------
      #2 rst = 1'b1;
      release_reset();
      halt_req = 1'b1;
      step(); check("boot_hreq.halted", {31'd0, halted}, 32'd1);
      check("boot_hreq.A", A, 32'h0);
      halt_req = 1'b0;

      // ---------------- wrap at top of address space ----------------
      #2 rst = 1'b1;
      release_reset();
      PCsrc = 1'b0;
      step();                                    // BOOT -> RUN
      PCsrc = 1'b1; ImmOp = 32'hFFFF_FFFC;
      step(); check("wrap_pre.A", A, 32'hFFFF_FFFC);
      check("wrap_pre.plus4", PCplus4, 32'h0);
      check("wrap_pre.cnt", instr_count, 32'd1);
      PCsrc = 1'b0;
      step(); check("wrap.A", A, 32'h0); check("wrap.cnt", instr_count, 32'd2);
      check("wrap.halted", {31'd0, halted}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #20000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_pc_fetch
